// File: rtl/passcode_entry_unit.sv
// Keypad front end for the secure room: conditions raw digit/enter/clear buttons
// and assembles a two-digit passcode that is presented for a fixed hold window.

module passcode_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // The counter only ever reaches DEBOUNCE_CYCLES-1 before the level flips,
    // so it can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            level_q <= level;
            if (sync != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// state | meaning
// IDLE  | no digits captured, outputs 00
// ONE   | first digit captured, inactivity timer running
// TWO   | both digits captured, waiting for ENTER, timer running
// HOLD  | passcode presented on the outputs for HOLD_CYCLES cycles
module passcode_entry_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 250,
    parameter int HOLD_CYCLES     = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_digit_raw,
    input  logic [1:0] key_value,
    input  logic       key_enter_raw,
    input  logic       key_clear_raw,
    output logic [1:0] passcode_digit_1,
    output logic [1:0] passcode_digit_2,
    output logic       code_valid,
    output logic [1:0] digits_entered,
    output logic       entry_error,
    output logic       entry_timeout
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state;
    logic            digit_evt;
    logic            enter_evt;
    logic            clear_evt;
    logic [1:0]      value_meta;
    logic [1:0]      value_sync;
    logic [1:0]      d1;
    logic [1:0]      d2;
    logic [TO_W-1:0] idle_cnt;
    logic [HD_W-1:0] hold_cnt;

    passcode_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (key_digit_raw),
        .press   (digit_evt)
    );

    passcode_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (key_enter_raw),
        .press   (enter_evt)
    );

    passcode_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (key_clear_raw),
        .press   (clear_evt)
    );

    // key_value is stable while the digit key is high, so a plain 2-flop
    // synchroniser is enough; it is read on the FSM action edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_meta <= 2'b00;
            value_sync <= 2'b00;
        end else begin
            value_meta <= key_value;
            value_sync <= value_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            d1               <= 2'b00;
            d2               <= 2'b00;
            idle_cnt         <= '0;
            hold_cnt         <= '0;
            passcode_digit_1 <= 2'b00;
            passcode_digit_2 <= 2'b00;
            code_valid       <= 1'b0;
            digits_entered   <= 2'd0;
            entry_error      <= 1'b0;
            entry_timeout    <= 1'b0;
        end else begin
            code_valid    <= 1'b0;
            entry_error   <= 1'b0;
            entry_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear_evt) begin
                        state <= S_IDLE;
                    end else if (enter_evt) begin
                        entry_error <= 1'b1;
                    end else if (digit_evt) begin
                        state          <= S_ONE;
                        d1             <= value_sync;
                        digits_entered <= 2'd1;
                        idle_cnt       <= '0;
                    end
                end
                S_ONE: begin
                    if (clear_evt || enter_evt) begin
                        entry_error    <= ~clear_evt;
                        state          <= S_IDLE;
                        d1             <= 2'b00;
                        d2             <= 2'b00;
                        digits_entered <= 2'd0;
                        idle_cnt       <= '0;
                    end else if (digit_evt) begin
                        state          <= S_TWO;
                        d2             <= value_sync;
                        digits_entered <= 2'd2;
                        idle_cnt       <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        entry_timeout  <= 1'b1;
                        state          <= S_IDLE;
                        d1             <= 2'b00;
                        d2             <= 2'b00;
                        digits_entered <= 2'd0;
                        idle_cnt       <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_TWO: begin
                    if (clear_evt) begin
                        state          <= S_IDLE;
                        d1             <= 2'b00;
                        d2             <= 2'b00;
                        digits_entered <= 2'd0;
                        idle_cnt       <= '0;
                    end else if (enter_evt) begin
                        state            <= S_HOLD;
                        passcode_digit_1 <= d1;
                        passcode_digit_2 <= d2;
                        code_valid       <= 1'b1;
                        hold_cnt         <= '0;
                        idle_cnt         <= '0;
                    end else if (digit_evt) begin
                        entry_error <= 1'b1;
                        idle_cnt    <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        entry_timeout  <= 1'b1;
                        state          <= S_IDLE;
                        d1             <= 2'b00;
                        d2             <= 2'b00;
                        digits_entered <= 2'd0;
                        idle_cnt       <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    // digit/enter are deliberately ignored while presenting
                    if (clear_evt || hold_cnt == HD_LAST) begin
                        state            <= S_IDLE;
                        d1               <= 2'b00;
                        d2               <= 2'b00;
                        passcode_digit_1 <= 2'b00;
                        passcode_digit_2 <= 2'b00;
                        digits_entered   <= 2'd0;
                        hold_cnt         <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/passcode_entry_unit.md
Name: passcode_entry_unit

Overview:
- Upstream front end of atm_secure_room_system. Receives raw keypad strobes and turns them into the 2-digit passcode bus the room controller consumes.
- Synchronises and debounces three buttons: digit, enter, clear.
- Collects two 2-bit digits in order. On ENTER it presents them on passcode_digit_1/2 for a fixed hold window.
- Also handles inactivity timeout and entry-error reporting.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a debounced button level changes (≥1).
- TIMEOUT_CYCLES, default 250: idle cycles in a partial entry before it is discarded (≥2).
- HOLD_CYCLES, default 50: cycles the accepted passcode stays on the outputs (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- key_digit_raw  in  1  raw digit-key strobe (asynchronous, bouncy)
- key_value  in  2  digit value; stable whenever key_digit_raw is high
- key_enter_raw  in  1  raw ENTER button (asynchronous, bouncy)
- key_clear_raw  in  1  raw CLEAR button (asynchronous, bouncy)
- passcode_digit_1  out  2  first digit to room controller; 00 outside HOLD
- passcode_digit_2  out  2  second digit to room controller; 00 outside HOLD
- code_valid  out  1  one-cycle pulse on the first cycle the passcode is presented
- digits_entered  out  2  count of captured digits: 0, 1 or 2
- entry_error  out  1  one-cycle pulse on an illegal key event
- entry_timeout  out  1  one-cycle pulse when a partial entry expires

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, FSM in IDLE, all counters and synchronisers 0, debounced levels 0.
- Reset mid-entry discards all digits.
- A button held through reset release produces one press event, after the normal debounce latency.
- Input conditioning: each raw button and key_value passes through a 2-flop synchroniser.
- Debounce counter: increments on each edge where the synchronised level differs from the debounced level; clears when they match.
- The debounced level toggles on the edge where the counter would reach DEBOUNCE_CYCLES.
- A press event is a debounced 0→1 transition. Releases generate no events.
- Latency: raw high first sampled at edge k gives debounced high after edge k+1+DEBOUNCE_CYCLES. The FSM acts at edge k+2+DEBOUNCE_CYCLES (k+6 with defaults), and outputs update after that edge.
- The digit value is taken from synchronised key_value at the FSM action edge.
- Event priority when several fire on the same edge: clear > enter > digit. Only the highest-priority event is acted on.
- FSM states and transitions:
  - IDLE, digits_entered=0.
    - digit → ONE, store d1.
    - enter → entry_error pulse, stay in IDLE.
    - clear → stay in IDLE.
  - ONE, digits_entered=1.
    - digit → TWO, store d2.
    - enter → entry_error pulse, go to IDLE.
    - clear → IDLE.
  - TWO, digits_entered=2.
    - digit → entry_error pulse, digit ignored, stay in TWO.
    - enter → HOLD.
    - clear → IDLE.
  - HOLD, digits_entered=2.
    - passcode_digit_1=d1 and passcode_digit_2=d2, held constant.
    - code_valid high on the first HOLD cycle only.
    - After exactly HOLD_CYCLES cycles in HOLD: outputs return to 00, go to IDLE, digits_entered=0.
    - digit/enter → ignored, no error.
    - clear → immediate IDLE; outputs 00 after that edge.
- Leaving ONE/TWO/HOLD for IDLE clears the stored d1/d2.
- Inactivity timer, active in ONE and TWO only:
  - Clears on every accepted event and on entry to ONE.
  - Counts one per cycle otherwise.
  - On reaching TIMEOUT_CYCLES: go to IDLE, entry_timeout pulse for one cycle, digits discarded.
  - A key event on the same edge as expiry wins; the timer restarts instead.
- Counter widths are $clog2(param+1). No counter wraps; all saturate or clear per the rules above.
- entry_error and entry_timeout are never asserted in the same cycle as code_valid.

Test Plan:
- Reset 5 cycles, release; press digit 01, then digit 10, then enter, each held 10 cycles, spaced 10 cycles → code_valid pulses once; passcode_digit_1=01 and passcode_digit_2=10 for exactly 50 cycles, then 00; digits_entered goes 1,2,2,0.
- Digit press with 3 one-cycle glitches before a stable high → exactly one press event. First FSM update lands 6 cycles after the stable level is first sampled.
- Enter after one digit → entry_error one pulse, digits_entered=0, outputs stay 00. Third digit in TWO → entry_error, digits unchanged.
- Enter one digit, then idle 250 cycles → entry_timeout pulse, digits_entered=0. Repeat with a second digit at cycle 249 → no timeout, digits_entered=2.
- Clear and enter debounced on the same edge in TWO → IDLE, no code_valid. Clear during HOLD → outputs 00 on the next cycle.
- Assert reset_n=0 asynchronously mid-HOLD → all outputs 0 immediately, without waiting for a clock edge. Hold the digit key through reset release → one capture into ONE after debounce.
